// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Owns the PC; handles stall, flush and branch redirect.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_data_i,
  output logic [31:0]      instr_o,
  output logic [15:0]      imm16_o,
  output logic [31:0]      pc_plus4_o,
  output logic             valid_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  typedef enum logic [1:0] {
    S_RESET    = 2'd0,
    S_RUN      = 2'd1,
    S_STALL    = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  logic [31:0]      pc_q;
  logic [31:0]      pc_inc;
  logic [31:0]      tgt;
  if_id_t           ifid_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  assign pc_inc = pc_q + 32'd4;
  assign tgt    = branch_target_i & ~32'd3;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      priority case (1'b1)
        branch_taken_i: pc_q <= tgt;
        stall_i:        pc_q <= pc_q;
        default:        pc_q <= pc_inc;
      endcase
    end
  end

  // Word fetched alongside a redirect is wrong-path: drop it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ifid_q <= '0;
    end else begin
      priority case (1'b1)
        flush_i:        ifid_q <= '0;
        branch_taken_i: ifid_q <= '0;
        stall_i:        ifid_q <= ifid_q;
        default: begin
          ifid_q.instr    <= imem_data_i;
          ifid_q.pc_plus4 <= pc_inc;
          ifid_q.valid    <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_RESET;
    end else if (state_q == S_RESET) begin
      state_q <= S_RUN;
    end else begin
      priority case (1'b1)
        branch_taken_i: state_q <= S_REDIRECT;
        flush_i:        state_q <= S_REDIRECT;
        stall_i:        state_q <= S_STALL;
        default:        state_q <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!ifid_q.valid && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign imem_addr_o  = pc_q;
  assign instr_o      = ifid_q.instr;
  assign imm16_o      = ifid_q.instr[15:0];
  assign pc_plus4_o   = ifid_q.pc_plus4;
  assign valid_o      = ifid_q.valid;
  assign state_o      = state_q;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the pipelined CPU.
- Owns the PC and drives the instruction-memory address.
- Latches the fetched word and PC+4 into the IF/ID register.
- Exposes instruction bits [15:0] directly as imm16_o, which feeds the sign extender in ID. Handles stall, flush and branch redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- stall_i  input  1  hazard stall from ID; hold PC and IF/ID.
- flush_i  input  1  squash IF/ID contents (insert bubble).
- branch_taken_i  input  1  redirect PC to branch_target_i this cycle.
- branch_target_i  input  32  redirect address; bits [1:0] ignored (treated as 00).
- imem_addr_o  output  32  instruction memory address; combinational equal to pc_q.
- imem_data_i  input  32  instruction word; combinational read, valid in the same cycle.
- instr_o  output  32  IF/ID instruction.
- imm16_o  output  16  instr_o[15:0], to sign extender.
- pc_plus4_o  output  32  IF/ID PC+4 of the latched instruction.
- valid_o  output  1  IF/ID holds a real instruction (0 = bubble/NOP).
- state_o  output  2  FSM state: 0=RESET, 1=RUN, 2=STALL, 3=REDIRECT.
- bubble_cnt_o  output  CNT_W  count of cycles since reset in which valid_o is 0; saturates at all-ones.

Behaviour:
- Reset (rst_i=1 at edge):
  - pc_q=RESET_PC; instr_o=0; pc_plus4_o=0; valid_o=0; bubble_cnt_o=0; state=RESET.
  - imem_addr_o therefore equals RESET_PC during and after reset.
- Reset mid-operation overrides everything, including pending stall, flush or redirect.
- PC update priority (highest first): rst_i > branch_taken_i > stall_i > increment.
  - Redirect: pc_q <= {branch_target_i[31:2],2'b00}.
  - Increment: pc_q <= pc_q+4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
  - A redirect is never lost, even when stall_i=1 in the same cycle.
- IF/ID update priority (highest first): rst_i > flush_i > branch_taken_i > stall_i > load.
  - flush or branch_taken: instr_o<=0, pc_plus4_o<=0, valid_o<=0 (the word fetched this cycle is wrong-path).
  - stall: all IF/ID outputs hold their values.
  - load: instr_o<=imem_data_i, pc_plus4_o<=pc_q+4, valid_o<=1.
- imm16_o is purely combinational from instr_o: 0 when in bubble, no added latency.
- Latency: a word presented at imem_addr_o in cycle N appears on instr_o after the edge ending cycle N (1 cycle).
- FSM next-state (evaluated each edge, rst_i forces RESET):
  - RESET -> RUN on the first edge with rst_i=0.
  - Any non-RESET state -> REDIRECT if branch_taken_i or flush_i.
  - Otherwise -> STALL if stall_i, else RUN.
  - REDIRECT lasts exactly one cycle unless re-triggered.
  - state_o is informational only; datapath priority rules above are authoritative.
- bubble_cnt_o increments on each edge where rst_i=0 and the registered valid_o is 0. It holds at 2^CNT_W-1.
- Stall with flush: IF/ID cleared, PC held (unless branch_taken_i). The stall continues to hold the bubble on the following cycles.
- No X propagation: imem_data_i is sampled only on load cycles.

Test Plan:
- Reset and run:
  - Stimulus: rst_i=1 for 2 cycles, release; imem returns addr+32'h1000_0000.
  - Required: imem_addr_o=0,4,8; instr_o=1000_0000 then 1000_0004; pc_plus4_o=4,8; valid_o=1 from the 2nd cycle after release; bubble_cnt_o=1.
- Stall:
  - Stimulus: stall_i=1 for 3 cycles at pc_q=8.
  - Required: imem_addr_o stays 8, instr_o/pc_plus4_o hold, state_o=2. Resume fetches 8 then 12.
- Branch during stall:
  - Stimulus: stall_i=1 and branch_taken_i=1 with branch_target_i=32'h0000_0043.
  - Required: next imem_addr_o=32'h40, valid_o=0, imm16_o=0, state_o=3. Next cycle loads the word at 0x40, pc_plus4_o=0x44.
- Flush:
  - Stimulus: flush_i=1 for one cycle at pc_q=0x20.
  - Required: valid_o=0, instr_o=0, PC advances to 0x24, bubble_cnt_o increments by 1.
- PC wrap:
  - Stimulus: redirect to 32'hFFFF_FFFC, then run.
  - Required: next imem_addr_o=0, pc_plus4_o for that instruction=0.
- Reset mid-operation and counter saturation:
  - Stimulus: rst_i asserted while stall_i=1 and a redirect is pending.
  - Required: all outputs return to reset values next cycle.
  - Stimulus (CNT_W=4): hold flush_i=1 for 20 cycles.
  - Required: bubble_cnt_o saturates at 15.
